// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the sample-rate datapath blocks.
// Holds the default word width/depth and an elaboration-time log2.
package dsp_pkg;

  localparam int DEF_WIDTH = 18;
  localparam int DEF_DEPTH = 32;

  // Ceiling log2, usable in parameter expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/srl_tap_mem.sv
// DEPTH x WIDTH shift array with an address-selected tap; address 0 is the newest word.
// Tap is combinational (zero latency); shifts only when ce is high, no flow control, no reset.
module srl_tap_mem
  import dsp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      ce,
  input  logic [WIDTH-1:0]          d,
  input  logic [clog2(DEPTH)-1:0]   addr,
  output logic [WIDTH-1:0]          q
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (ce) begin
      mem_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Left without reset so the array maps onto shift-register LUTs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign q = mem_q[addr];

endmodule

// File: rtl/var_delay_line.sv
// Variable delay line: y is d delayed by len+1 enabled cycles, qualified by a fill-count valid.
// Output registered; ce gates all progress, there is no backpressure; rst/clr/len change restart the fill.
module var_delay_line
  import dsp_pkg::*;
#(
  parameter int   WIDTH = DEF_WIDTH,
  parameter int   DEPTH = DEF_DEPTH,
  localparam int  AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    len,
  output logic [WIDTH-1:0] y,
  output logic             y_v
);

  logic [AW-1:0]    len_r_q, len_r_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_v_q, y_v_d;

  logic [WIDTH-1:0] tap;
  logic [AW:0]      len_p1;
  logic             full;
  logic             len_chg;

  srl_tap_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .ce   (ce),
    .d    (d),
    .addr (len_r_q),
    .q    (tap)
  );

  assign len_p1  = {1'b0, len_r_q} + {{AW{1'b0}}, 1'b1};
  // Tap holds a post-restart word once len_r+1 words have entered since the restart.
  assign full    = (cnt_q == len_p1);
  assign len_chg = (len != len_r_q);

  always_comb begin
    len_r_d = len_r_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    y_v_d   = y_v_q;
    if (clr) begin
      len_r_d = len;
      cnt_d   = '0;
      y_d     = '0;
      y_v_d   = 1'b0;
    end else if (len_chg) begin
      len_r_d = len;
      cnt_d   = '0;
      y_d     = '0;
      y_v_d   = 1'b0;
    end else if (ce) begin
      y_v_d = full;
      y_d   = full ? tap : '0;
      cnt_d = full ? cnt_q : cnt_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_r_q <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      y_v_q   <= 1'b0;
    end else begin
      len_r_q <= len_r_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_v_q   <= y_v_d;
    end
  end

  assign y   = y_q;
  assign y_v = y_v_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: stimulus pushes the expected {y_v, y} for each cycle,
// a monitor pops and compares one entry after every rising edge.
module tb_var_delay_line;

  localparam int WIDTH = 18;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             rst;
  logic             ce;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    len;
  logic [WIDTH-1:0] y;
  logic             y_v;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  var_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .clr (clr),
    .d   (d),
    .len (len),
    .y   (y),
    .y_v (y_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per edge, compared 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (y_v !== e.v || y !== e.y) begin
        errors++;
        $display("FAIL out cyc=%0d got y_v=%0b y=0x%05h expected y_v=%0b y=0x%05h",
                 cyc_no, y_v, y, e.v, e.y);
      end
    end
  end

  task automatic cyc(input logic i_rst, input logic i_ce, input logic i_clr,
                     input logic [AW-1:0] i_len, input logic [WIDTH-1:0] i_d,
                     input logic ev, input logic [WIDTH-1:0] ey);
    exp_t e;
    @(negedge clk);
    rst = i_rst;
    ce  = i_ce;
    clr = i_clr;
    len = i_len;
    d   = i_d;
    e.v = ev;
    e.y = ey;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] hold_y;
    logic             hold_v;
    rst = 1'b1; ce = 1'b0; clr = 1'b0; len = '0; d = '0;

    // Reset while seeding storage with all-ones; outputs must stay zero.
    for (int k = 0; k < 34; k++) cyc(1'b1, 1'b1, 1'b0, 5'd3, 18'h3FFFF, 1'b0, 18'h0);
    // Release; len 0->3 restarts with ce low, then a ramp at len=3.
    cyc(1'b0, 1'b0, 1'b0, 5'd3, 18'h0, 1'b0, 18'h0);
    for (int k = 1; k <= 12; k++)
      cyc(1'b0, 1'b1, 1'b0, 5'd3, 18'(k), (k >= 5), (k >= 5) ? 18'(k - 4) : 18'h0);

    // len=0 with ce every third cycle; idle cycles carry junk d and must hold.
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 18'h0, 1'b0, 18'h0);
    hold_v = 1'b0; hold_y = '0;
    for (int j = 1; j <= 6; j++) begin
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 18'h2AAAA, hold_v, hold_y);
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 18'h15555, hold_v, hold_y);
      hold_v = (j >= 2);
      hold_y = (j >= 2) ? 18'(100 + j - 1) : 18'h0;
      cyc(1'b0, 1'b1, 1'b0, 5'd0, 18'(100 + j), hold_v, hold_y);
    end

    // Maximum delay: len=31 gives 32 enabled cycles, valid first at edge 33.
    cyc(1'b0, 1'b0, 1'b0, 5'd31, 18'h0, 1'b0, 18'h0);
    for (int k = 1; k <= 40; k++)
      cyc(1'b0, 1'b1, 1'b0, 5'd31, 18'(k), (k >= 33), (k >= 33) ? 18'(k - 32) : 18'h0);

    // Fill at len=5, then retune to len=2 mid-stream with ce high.
    cyc(1'b0, 1'b0, 1'b0, 5'd5, 18'h0, 1'b0, 18'h0);
    for (int k = 1; k <= 12; k++)
      cyc(1'b0, 1'b1, 1'b0, 5'd5, 18'(200 + k), (k >= 7), (k >= 7) ? 18'(194 + k) : 18'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 18'd213, 1'b0, 18'h0);
    for (int m = 1; m <= 8; m++)
      cyc(1'b0, 1'b1, 1'b0, 5'd2, 18'(213 + m), (m >= 4), (m >= 4) ? 18'(210 + m) : 18'h0);

    // clr while valid; refill returns the first post-clr sample.
    cyc(1'b0, 1'b1, 1'b1, 5'd2, 18'd500, 1'b0, 18'h0);
    for (int m = 1; m <= 7; m++)
      cyc(1'b0, 1'b1, 1'b0, 5'd2, 18'(500 + m), (m >= 4), (m >= 4) ? 18'(497 + m) : 18'h0);

    // clr again, then rst mid-fill with all-ones data; those words must never surface.
    cyc(1'b0, 1'b1, 1'b1, 5'd2, 18'd600, 1'b0, 18'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 18'd601, 1'b0, 18'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 18'd602, 1'b0, 18'h0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 5'd2, 18'h3FFFF, 1'b0, 18'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 18'h3FFFF, 1'b0, 18'h0);
    for (int m = 1; m <= 8; m++)
      cyc(1'b0, 1'b1, 1'b0, 5'd2, 18'(700 + m), (m >= 4), (m >= 4) ? 18'(697 + m) : 18'h0);

    // Drain: the monitor must have consumed every expectation.
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
